// File: rtl/mau_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : mau_issue_if
// Purpose  : Bundles the RX-side push handshake, the decode-side issue
//            handshake, TX credit return, queue control and status of the
//            MAU issue scheduler.
// Modports : master - environment side (drives RX data, decode ready,
//                     tx_done, flush, drain_req; observes status)
//            slave  - scheduler side (mau_issue_ctrl)
// Revision : 1.0 - initial release
// ============================================================================
interface mau_issue_if #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 2
);
  localparam int c_QW = $clog2(DEPTH) + 1;
  localparam int c_IW = $clog2(MAX_INFLIGHT + 1);

  logic            in_valid;
  logic            in_ready;
  logic [39:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [39:0]     out_instr;
  logic            tx_done;
  logic            flush;
  logic            drain_req;
  logic            drained;
  logic [c_QW-1:0] q_count;
  logic [c_IW-1:0] inflight;
  logic [7:0]      drop_cnt;
  logic            drop_pulse;

  modport master (
    output in_valid, in_instr, out_ready, tx_done, flush, drain_req,
    input  in_ready, out_valid, out_instr, drained, q_count, inflight,
           drop_cnt, drop_pulse
  );

  modport slave (
    input  in_valid, in_instr, out_ready, tx_done, flush, drain_req,
    output in_ready, out_valid, out_instr, drained, q_count, inflight,
           drop_cnt, drop_pulse
  );
endinterface
`default_nettype wire

// File: rtl/mau_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mau_issue_ctrl
// Purpose  : Issue scheduler between MAU RX and decode. Buffers 40-bit
//            instructions in a DEPTH-entry FIFO, issues them only while the
//            number of issued-but-not-transmitted results is below
//            MAX_INFLIGHT (credits returned by tx_done), drops opcodes above
//            OP_MAX, supports a synchronous flush and a drain/quiesce mode.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset
//            bus   - mau_issue_if.slave (RX push, decode issue, tx_done,
//                    flush, drain_req, drained, q_count, inflight,
//                    drop_cnt, drop_pulse)
// Revision : 1.0 - initial release
// ============================================================================
module mau_issue_ctrl #(
  parameter int         DEPTH        = 4,
  parameter int         MAX_INFLIGHT = 2,
  parameter logic [7:0] OP_MAX       = 8'h0F
) (
  input wire logic   clk,
  input wire logic   rst_n,
  mau_issue_if.slave bus
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_QW = c_PW + 1;
  localparam int c_IW = $clog2(MAX_INFLIGHT + 1);

  localparam logic [c_QW-1:0] c_DEPTH   = c_QW'(DEPTH);
  localparam logic [c_IW-1:0] c_MAX_INF = c_IW'(MAX_INFLIGHT);

  localparam logic [1:0] c_ST_RUN     = 2'd0;
  localparam logic [1:0] c_ST_DRAIN   = 2'd1;
  localparam logic [1:0] c_ST_DRAINED = 2'd2;

  logic [39:0]     r_mem [DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_QW-1:0] r_count;
  logic [c_IW-1:0] r_inflight;
  logic [7:0]      r_drop_cnt;
  logic            r_drop_pulse;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_drained;
  logic w_legal;
  logic w_accept;
  logic w_push;
  logic w_drop;
  logic w_pop;
  logic w_credit;

  // --------------------------------------------------------------------------
  // Mode FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Mode FSM: next state. Dropping drain_req always wins, so an abandoned
  // drain returns straight to RUN.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN: begin
        if (bus.drain_req) w_state_nxt = c_ST_DRAIN;
      end
      c_ST_DRAIN: begin
        if (!bus.drain_req) begin
          w_state_nxt = c_ST_RUN;
        end else if ((r_count == '0) && (r_inflight == '0)) begin
          w_state_nxt = c_ST_DRAINED;
        end
      end
      c_ST_DRAINED: begin
        if (!bus.drain_req) w_state_nxt = c_ST_RUN;
      end
      default: w_state_nxt = c_ST_RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // Mode FSM: outputs. Handshakes depend only on registered state plus the
  // flush strobe, so a full FIFO never accepts in the same cycle it pops.
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_ready  = (r_state == c_ST_RUN) && (r_count < c_DEPTH) && !bus.flush;
    w_out_valid = (r_count != '0) && (r_inflight < c_MAX_INF) &&
                  !bus.flush && (r_state != c_ST_DRAINED);
    w_drained   = (r_state == c_ST_DRAINED);
  end

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign w_legal  = (bus.in_instr[39:32] <= OP_MAX);
  assign w_accept = bus.in_valid && w_in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_drop   = w_accept && !w_legal;
  assign w_pop    = w_out_valid && bus.out_ready;
  // A credit return with nothing outstanding is meaningless and is ignored.
  assign w_credit = bus.tx_done && (r_inflight != '0);

  // --------------------------------------------------------------------------
  // Entry storage; contents need no reset because out_valid gates them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_instr;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy. DEPTH is a power of two so pointers wrap
  // naturally.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_QW'(1);
        2'b01:   r_count <= r_count - c_QW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Credit counter. Not cleared by flush: already-issued work still has to
  // leave through TX.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else if (w_pop && !w_credit) begin
      r_inflight <= r_inflight + c_IW'(1);
    end else if (!w_pop && w_credit) begin
      r_inflight <= r_inflight - c_IW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Illegal-opcode accounting (saturating counter plus one-cycle pulse)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt   <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_instr  = r_mem[r_rd_ptr];
  assign bus.drained    = w_drained;
  assign bus.q_count    = r_count;
  assign bus.inflight   = r_inflight;
  assign bus.drop_cnt   = r_drop_cnt;
  assign bus.drop_pulse = r_drop_pulse;

endmodule
`default_nettype wire
